// File: rtl/alu_sequencer.sv
// alu_sequencer
// Control stage in front of the 8-bit ALU. It accepts one opcode at a time,
// fetches the operand from the register file, from (HL), or from the
// immediate byte at PC, and then drives the ALU opcode, operand,
// function-control, save-flags and write-back strobes for one cycle.
// Supported instructions: ALU A,r / ALU A,(HL) / ALU A,d8 and INC r / DEC r
// with r other than (HL). Any other opcode takes a one-cycle error pass that
// pulses o_Unsupported together with o_Done.
//
// Ports
//   i_Clk, i_Reset          clock and asynchronous active-high reset
//   i_Enable                clock enable; all state holds while it is low
//   i_Valid, i_Opcode       opcode offer; accepted when i_Valid & o_Ready & i_Enable
//   o_Ready                 high in IDLE while reset is released
//   o_Done, o_Unsupported   completion pulse / undecoded-opcode flag
//   o_Reg_Sel, i_Reg_Data   register-file read index and its data
//   o_Reg_Write, o_Reg_Wdata register write-back strobe and data (i_Result)
//   o_Mem_Req, o_Mem_Src    operand read request; source 0 = (HL), 1 = PC
//   i_Mem_Ack, i_Mem_Data   read completion and data
//   o_Opcode, o_Parameter   latched opcode and operand to the ALU
//   o_Function_Control      ALU unit select (main, incrementer, decrement, ...)
//   o_Save_Flags, o_A_Write flag commit and accumulator write strobes
//   i_Result                ALU result
module alu_sequencer (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic       i_Valid,
  input  logic [7:0] i_Opcode,
  output logic       o_Ready,
  output logic       o_Done,
  output logic       o_Unsupported,
  output logic [2:0] o_Reg_Sel,
  input  logic [7:0] i_Reg_Data,
  output logic       o_Reg_Write,
  output logic [7:0] o_Reg_Wdata,
  output logic       o_Mem_Req,
  output logic       o_Mem_Src,
  input  logic       i_Mem_Ack,
  input  logic [7:0] i_Mem_Data,
  output logic [7:0] o_Opcode,
  output logic [7:0] o_Parameter,
  output logic [5:0] o_Function_Control,
  output logic       o_Save_Flags,
  output logic       o_A_Write,
  input  logic [7:0] i_Result
);

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    EXEC,
    ERR
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_R,
    CLS_ALU_HL,
    CLS_ALU_IMM,
    CLS_INCDEC,
    CLS_UNSUP
  } op_class_t;

  function automatic op_class_t decode(input logic [7:0] op);
    op_class_t cls;
    cls = CLS_UNSUP;
    if (op[7:6] == 2'b10) begin
      if (op[2:0] == 3'd6) cls = CLS_ALU_HL;
      else                 cls = CLS_ALU_R;
    end else if (op[7:6] == 2'b11 && op[2:0] == 3'd6) begin
      cls = CLS_ALU_IMM;
    end else if (op[7:6] == 2'b00 && op[2:1] == 2'b10 && op[5:3] != 3'd6) begin
      cls = CLS_INCDEC;
    end
    return cls;
  endfunction

  state_t    state, state_next;
  logic [7:0] op_q;
  logic [7:0] operand_q;
  logic       transfer;
  op_class_t  in_cls;
  op_class_t  cur_cls;

  assign o_Ready  = (state == IDLE) && !i_Reset;
  assign transfer = i_Valid && o_Ready && i_Enable;
  assign in_cls   = decode(i_Opcode);
  assign cur_cls  = decode(op_q);
  assign o_Opcode = op_q;

  // State register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= IDLE;
    end else if (i_Enable) begin
      state <= state_next;
    end
  end

  // Opcode and operand latches
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      op_q      <= '0;
      operand_q <= '0;
    end else if (i_Enable) begin
      if (transfer) begin
        op_q <= i_Opcode;
      end
      if (state == MEM && i_Mem_Ack) begin
        operand_q <= i_Mem_Data;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (transfer) begin
          unique case (in_cls)
            CLS_ALU_R, CLS_INCDEC:   state_next = EXEC;
            CLS_ALU_HL, CLS_ALU_IMM: state_next = MEM;
            default:                 state_next = ERR;
          endcase
        end
      end
      MEM:     if (i_Mem_Ack) state_next = EXEC;
      EXEC:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; only o_Parameter and o_Reg_Wdata are combinational pass-throughs
  always_comb begin
    o_Done             = 1'b0;
    o_Unsupported      = 1'b0;
    o_Reg_Sel          = '0;
    o_Reg_Write        = 1'b0;
    o_Mem_Req          = 1'b0;
    o_Mem_Src          = 1'b0;
    o_Parameter        = '0;
    o_Function_Control = '0;
    o_Save_Flags       = 1'b0;
    o_A_Write          = 1'b0;
    o_Reg_Wdata        = i_Reset ? '0 : i_Result;
    unique case (state)
      MEM: begin
        o_Mem_Req = 1'b1;
        o_Mem_Src = op_q[6];
      end
      EXEC: begin
        o_Done = 1'b1;
        unique case (cur_cls)
          CLS_ALU_R: begin
            o_Reg_Sel          = op_q[2:0];
            o_Parameter        = i_Reg_Data;
            o_Function_Control = 6'b000001;
            o_Save_Flags       = 1'b1;
            o_A_Write          = (op_q[5:3] != 3'd7);
          end
          CLS_ALU_HL, CLS_ALU_IMM: begin
            o_Parameter        = operand_q;
            o_Function_Control = 6'b000001;
            o_Save_Flags       = 1'b1;
            o_A_Write          = (op_q[5:3] != 3'd7);
          end
          CLS_INCDEC: begin
            // op[0] distinguishes DEC (x5) from INC (x4)
            o_Reg_Sel          = op_q[5:3];
            o_Parameter        = i_Reg_Data;
            o_Function_Control = {3'b000, op_q[0], 1'b1, 1'b0};
            o_Save_Flags       = 1'b1;
            o_A_Write          = (op_q[5:3] == 3'd7);
            o_Reg_Write        = (op_q[5:3] != 3'd7);
          end
          default: ;
        endcase
      end
      ERR: begin
        o_Done        = 1'b1;
        o_Unsupported = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_Enable;
  logic       i_Valid;
  logic [7:0] i_Opcode;
  logic       o_Ready;
  logic       o_Done;
  logic       o_Unsupported;
  logic [2:0] o_Reg_Sel;
  logic [7:0] i_Reg_Data;
  logic       o_Reg_Write;
  logic [7:0] o_Reg_Wdata;
  logic       o_Mem_Req;
  logic       o_Mem_Src;
  logic       i_Mem_Ack;
  logic [7:0] i_Mem_Data;
  logic [7:0] o_Opcode;
  logic [7:0] o_Parameter;
  logic [5:0] o_Function_Control;
  logic       o_Save_Flags;
  logic       o_A_Write;
  logic [7:0] i_Result;

  logic [7:0] regs [8];
  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_sequencer dut (
    .i_Clk              (i_Clk),
    .i_Reset            (i_Reset),
    .i_Enable           (i_Enable),
    .i_Valid            (i_Valid),
    .i_Opcode           (i_Opcode),
    .o_Ready            (o_Ready),
    .o_Done             (o_Done),
    .o_Unsupported      (o_Unsupported),
    .o_Reg_Sel          (o_Reg_Sel),
    .i_Reg_Data         (i_Reg_Data),
    .o_Reg_Write        (o_Reg_Write),
    .o_Reg_Wdata        (o_Reg_Wdata),
    .o_Mem_Req          (o_Mem_Req),
    .o_Mem_Src          (o_Mem_Src),
    .i_Mem_Ack          (i_Mem_Ack),
    .i_Mem_Data         (i_Mem_Data),
    .o_Opcode           (o_Opcode),
    .o_Parameter        (o_Parameter),
    .o_Function_Control (o_Function_Control),
    .o_Save_Flags       (o_Save_Flags),
    .o_A_Write          (o_A_Write),
    .i_Result           (i_Result)
  );

  always #5 i_Clk = ~i_Clk;

  // Register-file read port model
  always_comb i_Reg_Data = regs[o_Reg_Sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    i_Reset    = 1'b1;
    i_Enable   = 1'b1;
    i_Valid    = 1'b0;
    i_Opcode   = 8'h00;
    i_Mem_Ack  = 1'b0;
    i_Mem_Data = 8'h00;
    i_Result   = 8'h00;
    #1;
    check("rst_ready",  32'(o_Ready), 0);
    check("rst_done",   32'(o_Done), 0);
    check("rst_memreq", 32'(o_Mem_Req), 0);
    check("rst_opcode", 32'(o_Opcode), 32'h00);
    check("rst_fc",     32'(o_Function_Control), 0);
    tick;
    tick;
    i_Reset = 1'b0;
    #1;
    check("rel_ready", 32'(o_Ready), 1);

    // Enable low in IDLE: offer ignored
    i_Enable = 1'b0;
    i_Valid  = 1'b1;
    i_Opcode = 8'h80;
    tick;
    check("en0_ready",  32'(o_Ready), 1);
    check("en0_done",   32'(o_Done), 0);
    check("en0_opcode", 32'(o_Opcode), 32'h00);
    i_Enable = 1'b1;

    // ADD A,B
    regs[0]  = 8'h3A;
    i_Result = 8'h7C;
    i_Valid  = 1'b1;
    i_Opcode = 8'h80;
    tick;
    i_Valid = 1'b0;
    #1;
    check("add_sel",    32'(o_Reg_Sel), 0);
    check("add_param",  32'(o_Parameter), 32'h3A);
    check("add_fc",     32'(o_Function_Control), 32'b000001);
    check("add_awr",    32'(o_A_Write), 1);
    check("add_rwr",    32'(o_Reg_Write), 0);
    check("add_save",   32'(o_Save_Flags), 1);
    check("add_done",   32'(o_Done), 1);
    check("add_ready",  32'(o_Ready), 0);
    check("add_opcode", 32'(o_Opcode), 32'h80);
    tick;
    check("add_ready2", 32'(o_Ready), 1);
    check("add_done2",  32'(o_Done), 0);

    // CP d8 with ack in the third request cycle
    i_Valid  = 1'b1;
    i_Opcode = 8'hFE;
    tick;
    i_Valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        i_Mem_Ack  = 1'b1;
        i_Mem_Data = 8'h42;
      end
      #1;
      check("cp_req",   32'(o_Mem_Req), 1);
      check("cp_src",   32'(o_Mem_Src), 1);
      check("cp_ready", 32'(o_Ready), 0);
      tick;
    end
    i_Mem_Ack  = 1'b0;
    i_Mem_Data = 8'h00;
    #1;
    check("cp_req_off", 32'(o_Mem_Req), 0);
    check("cp_param",   32'(o_Parameter), 32'h42);
    check("cp_fc",      32'(o_Function_Control), 32'b000001);
    check("cp_save",    32'(o_Save_Flags), 1);
    check("cp_awr",     32'(o_A_Write), 0);
    check("cp_done",    32'(o_Done), 1);
    tick;

    // DEC C
    regs[1]  = 8'h01;
    i_Result = 8'h00;
    i_Valid  = 1'b1;
    i_Opcode = 8'h0D;
    tick;
    i_Valid = 1'b0;
    #1;
    check("dec_sel",   32'(o_Reg_Sel), 1);
    check("dec_param", 32'(o_Parameter), 32'h01);
    check("dec_fc",    32'(o_Function_Control), 32'b000110);
    check("dec_rwr",   32'(o_Reg_Write), 1);
    check("dec_wdata", 32'(o_Reg_Wdata), 32'h00);
    check("dec_awr",   32'(o_A_Write), 0);
    check("dec_save",  32'(o_Save_Flags), 1);
    tick;

    // INC A
    regs[7]  = 8'h10;
    i_Result = 8'h11;
    i_Valid  = 1'b1;
    i_Opcode = 8'h3C;
    tick;
    i_Valid = 1'b0;
    #1;
    check("inc_sel",   32'(o_Reg_Sel), 7);
    check("inc_param", 32'(o_Parameter), 32'h10);
    check("inc_fc",    32'(o_Function_Control), 32'b000010);
    check("inc_awr",   32'(o_A_Write), 1);
    check("inc_rwr",   32'(o_Reg_Write), 0);
    tick;

    // NOP is unsupported
    i_Valid  = 1'b1;
    i_Opcode = 8'h00;
    tick;
    i_Valid = 1'b0;
    #1;
    check("nop_done",  32'(o_Done), 1);
    check("nop_unsup", 32'(o_Unsupported), 1);
    check("nop_awr",   32'(o_A_Write), 0);
    check("nop_rwr",   32'(o_Reg_Write), 0);
    check("nop_save",  32'(o_Save_Flags), 0);
    check("nop_fc",    32'(o_Function_Control), 0);
    check("nop_req",   32'(o_Mem_Req), 0);
    tick;
    check("nop_unsup2", 32'(o_Unsupported), 0);
    check("nop_ready2", 32'(o_Ready), 1);

    // ADD A,(HL) interrupted by reset in MEM
    i_Valid  = 1'b1;
    i_Opcode = 8'h86;
    tick;
    i_Valid = 1'b0;
    #1;
    check("hl_req", 32'(o_Mem_Req), 1);
    check("hl_src", 32'(o_Mem_Src), 0);
    i_Reset = 1'b1;
    #1;
    check("hl_rst_req",   32'(o_Mem_Req), 0);
    check("hl_rst_ready", 32'(o_Ready), 0);
    tick;
    i_Reset = 1'b0;
    #1;
    check("hl_rel_ready",  32'(o_Ready), 1);
    check("hl_rel_opcode", 32'(o_Opcode), 32'h00);
    i_Mem_Ack  = 1'b1;
    i_Mem_Data = 8'h55;
    tick;
    i_Mem_Ack = 1'b0;
    #1;
    check("hl_ack_done",  32'(o_Done), 0);
    check("hl_ack_req",   32'(o_Mem_Req), 0);
    check("hl_ack_ready", 32'(o_Ready), 1);

    // Enable low while in EXEC holds the done cycle
    regs[1]  = 8'h27;
    i_Result = 8'h99;
    i_Valid  = 1'b1;
    i_Opcode = 8'h81;
    tick;
    i_Valid  = 1'b0;
    i_Enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("hold_done",  32'(o_Done), 1);
      check("hold_param", 32'(o_Parameter), 32'h27);
      check("hold_ready", 32'(o_Ready), 0);
      tick;
    end
    i_Enable = 1'b1;
    #1;
    check("hold_done_last", 32'(o_Done), 1);
    tick;
    check("hold_exit_done",  32'(o_Done), 0);
    check("hold_exit_ready", 32'(o_Ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
